// File: rtl/br_stack.sv
// Branch checkpoint store: one map-table / free-list-head snapshot per branch-mask bit.
// Snapshots on dispatch, replays one on mispredict, releases on correct resolution.
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'd1
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'd2
`endif

module br_stack #(
  parameter int BR_MASK_W = 5,
  parameter int ARCH_NUM  = 32,
  parameter int PRF_IDX_W = 6,
  parameter int FL_PTR_W  = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          br_push_i,
  input  logic [BR_MASK_W-1:0]          br_mask_i,
  input  logic [ARCH_NUM*PRF_IDX_W-1:0] map_i,
  input  logic [FL_PTR_W-1:0]           fl_head_i,
  input  logic [`BR_STATE_W-1:0]        br_state_i,
  input  logic [BR_MASK_W-1:0]          br_bit_i,
  input  logic [BR_MASK_W-1:0]          br_dep_mask_i,
  output logic                          rc_valid_o,
  output logic [ARCH_NUM*PRF_IDX_W-1:0] rc_map_o,
  output logic [FL_PTR_W-1:0]           rc_fl_head_o,
  output logic [BR_MASK_W-1:0]          valid_o,
  output logic                          full_o,
  output logic                          ovf_err_o
);

  localparam int MAP_W = ARCH_NUM * PRF_IDX_W;
  localparam int IDX_W = (BR_MASK_W > 1) ? $clog2(BR_MASK_W) : 1;

  logic [MAP_W-1:0]     slot_map  [BR_MASK_W];
  logic [FL_PTR_W-1:0]  slot_head [BR_MASK_W];
  logic [BR_MASK_W-1:0] valid_q;

  logic                 is_wrong;
  logic                 is_correct;
  logic                 bit_any;
  logic [BR_MASK_W-1:0] base;
  logic                 base_full;
  logic [IDX_W-1:0]     alloc_idx;
  logic [IDX_W-1:0]     res_idx;
  logic                 push_ok;
  logic                 push_drop;
  logic                 res_bad;
  logic [BR_MASK_W-1:0] valid_nxt;

  assign is_wrong   = (br_state_i == `BR_PR_WRONG);
  assign is_correct = (br_state_i == `BR_PR_CORRECT);
  assign bit_any    = |br_bit_i;
  assign base       = is_correct ? (br_mask_i & ~br_bit_i) : br_mask_i;
  assign base_full  = &base;

  // Lowest zero bit of base: scan high-to-low so the lowest index wins.
  always_comb begin
    alloc_idx = '0;
    for (int i = BR_MASK_W - 1; i >= 0; i--) begin
      if (!base[i]) alloc_idx = IDX_W'(i);
    end
  end

  always_comb begin
    res_idx = '0;
    for (int i = 0; i < BR_MASK_W; i++) begin
      if (br_bit_i[i]) res_idx = IDX_W'(i);
    end
  end

  assign push_ok   = br_push_i && !is_wrong && !base_full;
  assign push_drop = br_push_i && !is_wrong && base_full;
  assign res_bad   = (is_correct || is_wrong) && bit_any && !(|(valid_q & br_bit_i));

  always_comb begin
    valid_nxt = valid_q;
    if (is_correct && bit_any) valid_nxt = valid_q & ~br_bit_i;
    if (is_wrong && bit_any)   valid_nxt = valid_q & br_dep_mask_i;
    if (push_ok)               valid_nxt[alloc_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      rc_valid_o   <= 1'b0;
      rc_map_o     <= '0;
      rc_fl_head_o <= '0;
      ovf_err_o    <= 1'b0;
    end else begin
      valid_q    <= valid_nxt;
      rc_valid_o <= is_wrong && bit_any;
      if (is_wrong && bit_any) begin
        rc_map_o     <= slot_map[res_idx];
        rc_fl_head_o <= slot_head[res_idx];
      end
      if (push_drop || res_bad) ovf_err_o <= 1'b1;
    end
  end

  // Slot payload carries no reset; only the valid vector gives it meaning.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      slot_map[alloc_idx]  <= map_i;
      slot_head[alloc_idx] <= fl_head_i;
    end
  end

  assign valid_o = valid_q;
  assign full_o  = &valid_q;

endmodule
